mem_port_arbiter: RTL and testbench

- Shares the single byte-addressed unified SRAM between two requesters: instruction fetch (I port) and load/store unit (D port).
- Arbitrates between them, keeps one access outstanding, and generates SRAM byte enables and lane-steered write data for SB/SH/SW.
- Aligns and sign- or zero-extends load data, and flags misaligned data accesses.
- Sits between the core pipeline and the SRAM. It is the only driver of the SRAM addr/datain/wen/ben.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and SRAM signal bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDRLEN = 16,
    parameter int XLEN    = 32
);
    logic               i_req;
    logic [ADDRLEN-1:0] i_addr;
    logic               i_gnt;
    logic               i_rvalid;
    logic [XLEN-1:0]    i_rdata;

    logic               d_req;
    logic               d_we;
    logic [ADDRLEN-1:0] d_addr;
    logic [1:0]         d_size;
    logic               d_unsigned;
    logic [XLEN-1:0]    d_wdata;
    logic               d_gnt;
    logic               d_rvalid;
    logic [XLEN-1:0]    d_rdata;
    logic               d_err;

    logic [ADDRLEN-1:0] mem_addr;
    logic [XLEN-1:0]    mem_wdata;
    logic               mem_wen;
    logic [3:0]         mem_ben;
    logic [XLEN-1:0]    mem_rdata;

    // Core requesters and SRAM together form the master side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_wen, mem_ben
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_wen, mem_ben
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (fetch / load-store) arbiter onto one byte-addressed
//               SRAM with lane steering, load extension and alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDRLEN      = 16,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t             r_state;
    logic [3:0]         r_starve;
    logic               r_own_i;
    logic               r_we;
    logic               r_uns;
    logic [1:0]         r_size;
    logic [ADDRLEN-1:0] r_addr;
    logic [XLEN-1:0]    r_wdata;

    logic               r_i_rvalid;
    logic [XLEN-1:0]    r_i_rdata;
    logic               r_d_rvalid;
    logic               r_d_err;
    logic [XLEN-1:0]    r_d_rdata;

    logic               w_idle;
    logic               w_acc;
    logic               w_i_pri;
    logic               w_d_gnt;
    logic               w_i_gnt;
    logic               w_err;
    logic               w_dst;
    logic [3:0]         w_ben;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_rshift;
    logic [XLEN-1:0]    w_ld;

    // Grants only from IDLE and never while reset is asserted.
    assign w_idle  = (r_state == ST_IDLE) && !rst;
    assign w_acc   = (r_state == ST_ACCESS) && !rst;
    assign w_i_pri = (r_starve == c_STARVE_LIMIT);
    assign w_d_gnt = w_idle && bus.d_req && !(bus.i_req && w_i_pri);
    assign w_i_gnt = w_idle && bus.i_req && !w_d_gnt;

    always_comb begin
        w_err = 1'b0;
        case (r_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = r_addr[0];
            2'd2:    w_err = (r_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_ben   = 4'b0000;
        w_wdata = '0;
        case (r_size)
            2'd0: begin
                w_ben   = 4'b0001 << r_addr[1:0];
                w_wdata = {{(XLEN-8){1'b0}}, r_wdata[7:0]} << {r_addr[1:0], 3'b000};
            end
            2'd1: begin
                w_ben   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {{(XLEN-16){1'b0}}, r_wdata[15:0]} << {r_addr[1], 4'b0000};
            end
            2'd2: begin
                w_ben   = 4'b1111;
                w_wdata = r_wdata;
            end
            default: begin
                w_ben   = 4'b0000;
                w_wdata = '0;
            end
        endcase
    end

    assign w_dst         = w_acc && !r_own_i && r_we && !w_err;
    assign bus.i_gnt     = w_i_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_addr  = w_acc ? r_addr : '0;
    assign bus.mem_wen   = w_dst;
    assign bus.mem_ben   = w_dst ? w_ben : 4'b0000;
    assign bus.mem_wdata = w_dst ? w_wdata : '0;

    // Shift the addressed lane down to bit 0 before extending.
    assign w_rshift = bus.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld = '0;
        if (!r_we && !w_err) begin
            case (r_size)
                2'd0:    w_ld = {{(XLEN-8){w_rshift[7] & ~r_uns}}, w_rshift[7:0]};
                2'd1:    w_ld = {{(XLEN-16){w_rshift[15] & ~r_uns}}, w_rshift[15:0]};
                2'd2:    w_ld = w_rshift;
                default: w_ld = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_starve   <= 4'd0;
            r_own_i    <= 1'b0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_i_gnt || w_d_gnt) begin
                        r_state <= ST_ACCESS;
                        r_own_i <= w_i_gnt;
                        r_we    <= w_d_gnt && bus.d_we;
                        r_uns   <= bus.d_unsigned;
                        r_size  <= w_i_gnt ? 2'd2 : bus.d_size;
                        r_addr  <= w_i_gnt ? {bus.i_addr[ADDRLEN-1:2], 2'b00} : bus.d_addr;
                        r_wdata <= bus.d_wdata;
                    end
                    if (w_i_gnt) begin
                        r_starve <= 4'd0;
                    end else if (w_d_gnt && bus.i_req) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_IDLE;
                    if (r_own_i) begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= bus.mem_rdata;
                    end else begin
                        r_d_rvalid <= 1'b1;
                        r_d_err    <= w_err;
                        r_d_rdata  <= w_ld;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_err    = r_d_err;
    assign bus.d_rdata  = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   wen_cnt;
    logic [31:0] mem [0:63];

    mem_port_arbiter_if #(.ADDRLEN(16), .XLEN(32)) bus ();

    mem_port_arbiter #(
        .ADDRLEN      (16),
        .XLEN         (32),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_wen === 1'b1) begin
            wen_cnt <= wen_cnt + 1;
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_ben[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic d_op(input logic we, input logic [15:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output logic [3:0] ben, output logic rv);
        logic got;
        @(negedge clk);
        bus.d_we = we; bus.d_addr = a; bus.d_size = sz;
        bus.d_unsigned = uns; bus.d_wdata = wd; bus.d_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (bus.d_gnt === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk("d_gnt_seen", 32'(got), 32'd1);
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        ben = bus.mem_ben;
        @(negedge clk);
        #1;
        rv  = bus.d_rvalid;
        rd  = bus.d_rdata;
        err = bus.d_err;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [3:0]  bn;
    logic        rv;
    int          w0;
    int          gc;
    int          n;
    int          both;
    int          ng;
    int          nr;
    int          gcy [0:3];
    int          rcy [0:3];
    logic [9:0]  starve_exp;
    logic        got;

    initial begin
        total = 0; bad = 0; cyc = 0; wen_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_size = 2'd0; bus.d_unsigned = 1'b0; bus.d_wdata = '0;
        rst = 1'b1;

        // Reset state with both requests asserted: nothing may be granted.
        repeat (2) @(negedge clk);
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        #1;
        chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        chk("rst_outs", {bus.mem_wen, bus.mem_ben, bus.i_rvalid, bus.d_rvalid, bus.d_err}, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        rst = 1'b0;

        // Reset during the ACCESS cycle of a store aborts it.
        @(negedge clk);
        bus.d_we = 1'b1; bus.d_addr = 16'h10; bus.d_size = 2'd2; bus.d_wdata = 32'hDEADBEEF;
        bus.d_req = 1'b1;
        #1;
        chk("abort_gnt", 32'(bus.d_gnt), 32'd1);
        @(negedge clk);
        bus.d_req = 1'b0; rst = 1'b1;
        #1;
        chk("abort_wen", 32'(bus.mem_wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        d_op(1'b0, 16'h10, 2'd2, 1'b0, 32'h0, rd, er, bn, rv);
        chk("abort_lw_rv", 32'(rv), 32'd1);
        chk("abort_lw_data", rd, 32'h00000000);

        // Byte/half stores and extended loads.
        d_op(1'b1, 16'h20, 2'd2, 1'b0, 32'h11223344, rd, er, bn, rv);
        chk("sw_ben", 32'(bn), 32'h0000000F);
        d_op(1'b1, 16'h21, 2'd0, 1'b0, 32'h000000AA, rd, er, bn, rv);
        chk("sb_ben", 32'(bn), 32'h00000002);
        d_op(1'b1, 16'h22, 2'd1, 1'b0, 32'h00008001, rd, er, bn, rv);
        chk("sh_ben", 32'(bn), 32'h0000000C);
        chk("sh_rdata_zero", rd, 32'h0);
        d_op(1'b0, 16'h20, 2'd2, 1'b0, 32'h0, rd, er, bn, rv);
        chk("lw_0x20", rd, 32'h8001AA44);
        chk("lw_ben", 32'(bn), 32'h0);
        d_op(1'b0, 16'h21, 2'd0, 1'b0, 32'h0, rd, er, bn, rv);
        chk("lb_0x21", rd, 32'hFFFFFFAA);
        d_op(1'b0, 16'h21, 2'd0, 1'b1, 32'h0, rd, er, bn, rv);
        chk("lbu_0x21", rd, 32'h000000AA);
        d_op(1'b0, 16'h22, 2'd1, 1'b0, 32'h0, rd, er, bn, rv);
        chk("lh_0x22", rd, 32'hFFFF8001);
        d_op(1'b0, 16'h22, 2'd1, 1'b1, 32'h0, rd, er, bn, rv);
        chk("lhu_0x22", rd, 32'h00008001);
        chk("lhu_err", 32'(er), 32'd0);

        // Misaligned and illegal-size accesses.
        w0 = wen_cnt;
        d_op(1'b1, 16'h22, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, bn, rv);
        chk("mis_sw_err", {rv, er, bn}, {26'd0, 1'b1, 1'b1, 4'b0000});
        chk("mis_sw_rdata", rd, 32'h0);
        d_op(1'b0, 16'h23, 2'd1, 1'b0, 32'h0, rd, er, bn, rv);
        chk("mis_lh_err", {rv, er, bn}, {26'd0, 1'b1, 1'b1, 4'b0000});
        chk("mis_lh_rdata", rd, 32'h0);
        d_op(1'b1, 16'h20, 2'd3, 1'b0, 32'h12345678, rd, er, bn, rv);
        chk("ill_size_err", {rv, er, bn}, {26'd0, 1'b1, 1'b1, 4'b0000});
        chk("ill_size_rdata", rd, 32'h0);
        chk("mis_no_wen", 32'(wen_cnt - w0), 32'd0);
        d_op(1'b0, 16'h20, 2'd2, 1'b0, 32'h0, rd, er, bn, rv);
        chk("mis_mem_kept", rd, 32'h8001AA44);

        // Fetch from an unaligned address reads the containing word.
        @(negedge clk);
        bus.i_addr = 16'h23; bus.i_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (bus.i_gnt === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk("i_gnt_seen", 32'(got), 32'd1);
        gc = cyc;
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h20);
        chk("fetch_no_early_rv", 32'(bus.i_rvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("fetch_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("fetch_latency", 32'(cyc - gc), 32'd2);
        chk("fetch_rdata", bus.i_rdata, 32'h8001AA44);

        // Both ports requesting continuously: I wins every fifth grant.
        starve_exp = 10'b10_0001_0000;
        @(negedge clk);
        bus.i_addr = 16'h0; bus.d_we = 1'b0; bus.d_addr = 16'h20; bus.d_size = 2'd2;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        n = 0; both = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.i_gnt === 1'b1 && bus.d_gnt === 1'b1) both++;
            if (bus.i_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
                if (n < 10) chk("starve_seq_i", 32'(bus.i_gnt), 32'(starve_exp[n]));
                n++;
            end
            @(negedge clk);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("starve_grants", 32'(n), 32'd10);
        chk("starve_never_both", 32'(both), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back loads with d_req held.
        bus.d_we = 1'b0; bus.d_addr = 16'h20; bus.d_size = 2'd2; bus.d_req = 1'b1;
        ng = 0; nr = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.d_gnt === 1'b1 && ng < 4) begin gcy[ng] = cyc; ng++; end
            if (bus.d_rvalid === 1'b1 && nr < 4) begin
                rcy[nr] = cyc; nr++;
                chk("b2b_rdata", bus.d_rdata, 32'h8001AA44);
            end
            @(negedge clk);
            if (ng >= 3) bus.d_req = 1'b0;
        end
        chk("b2b_ngrants", 32'(ng), 32'd3);
        chk("b2b_nrvalid", 32'(nr), 32'd3);
        if (ng == 3 && nr == 3) begin
            chk("b2b_gnt1", 32'(gcy[1] - gcy[0]), 32'd2);
            chk("b2b_gnt2", 32'(gcy[2] - gcy[0]), 32'd4);
            for (int i = 0; i < 3; i++) chk("b2b_rv_lat", 32'(rcy[i] - gcy[i]), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
